// File: rtl/ddr2_pkg.sv
// Shared definitions for the DDR2 read/write engines on the MIG native app port.
package ddr2_pkg;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    localparam int APP_ADDR_W = 27;
    localparam int APP_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT_DATA,
        ACK
    } rd_state_t;

endpackage

// File: rtl/ddr2_rd.sv
// DDR2 read engine: one 128-bit read per strobe, issued on the MIG app port,
// with a timeout abort and a counter that discards beats of aborted reads.
//
// state     | meaning
// IDLE      | waiting for stb_i with calibration complete
// CMD       | app_en asserted, waiting for app_rdy
// WAIT_DATA | command accepted, waiting for the burst beat or timeout
// ACK       | ack_o pulse, err_o qualifies the result
module ddr2_rd
    import ddr2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int DROP_W         = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [APP_ADDR_W-1:0] addr_i,
    input  logic                  stb_i,
    output logic [APP_DATA_W-1:0] data_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  busy_o,
    input  logic                  init_calib_complete,
    output logic                  app_en,
    output logic [2:0]            app_cmd,
    output logic [APP_ADDR_W-1:0] app_addr,
    input  logic                  app_rdy,
    input  logic [APP_DATA_W-1:0] app_rd_data,
    input  logic                  app_rd_data_valid,
    input  logic                  app_rd_data_end
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    rd_state_t             state_q, state_d;
    logic [APP_ADDR_W-1:0] addr_q, addr_d;
    logic [APP_DATA_W-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [DROP_W-1:0]     drop_q, drop_d;

    logic beat_end, discard, accept, timeout, start;

    assign beat_end = app_rd_data_valid && app_rd_data_end;
    assign discard  = beat_end && (drop_q != '0);
    assign accept   = beat_end && (drop_q == '0) && (state_q == WAIT_DATA);
    assign timeout  = (state_q == WAIT_DATA) && !accept && (tmr_q == TMR_LAST);
    assign start    = (state_q == IDLE) && stb_i && init_calib_complete;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = CMD;
            CMD:       if (app_rdy) state_d = WAIT_DATA;
            WAIT_DATA: if (accept || timeout) state_d = ACK;
            ACK:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        app_en = (state_q == CMD);
        ack_o  = (state_q == ACK);
        busy_o = (state_q != IDLE);
    end

    always_comb begin
        addr_d = start ? (addr_i & ~APP_ADDR_W'(7)) : addr_q;
        data_d = accept ? app_rd_data : data_q;
        err_d  = accept ? 1'b0 : (timeout ? 1'b1 : err_q);

        tmr_d = tmr_q;
        if ((state_q == CMD) && app_rdy) begin
            tmr_d = '0;
        end else if ((state_q == WAIT_DATA) && (tmr_q != TMR_MAX)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        // A timeout and a discard in the same cycle cancel out.
        drop_d = drop_q;
        case ({timeout, discard})
            2'b10:   if (drop_q != DROP_MAX) drop_d = drop_q + DROP_W'(1);
            2'b01:   drop_d = drop_q - DROP_W'(1);
            default: drop_d = drop_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            tmr_q  <= '0;
            drop_q <= '0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            err_q  <= err_d;
            tmr_q  <= tmr_d;
            drop_q <= drop_d;
        end
    end

    assign data_o   = data_q;
    assign err_o    = err_q;
    assign app_addr = addr_q;
    assign app_cmd  = APP_CMD_READ;

endmodule
